// File: rtl/glitch_filter_pkg.sv
// Shared types and default parameter values for the multi-channel glitch filter.
package glitch_filter_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int DEF_WIDTH         = 4;
  localparam int DEF_FILTER_CYCLES = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_CNT_W         = 8;

  // Stability counter width; a single-cycle filter still keeps a 1-bit counter.
  function automatic int cnt_width(input int filter_cycles);
    return (filter_cycles > 1) ? $clog2(filter_cycles) : 1;
  endfunction

endpackage

// File: rtl/glitch_filter_if.sv
// Control, data and status bundle between the glitch filter and its user.
interface glitch_filter_if
  import glitch_filter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             en;
  logic             clr_cnt;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] glitch;
  logic [CNT_W-1:0] glitch_count;

  modport master (
    output en, clr_cnt, din,
    input  dout, rise, fall, glitch, glitch_count
  );

  modport slave (
    input  en, clr_cnt, din,
    output dout, rise, fall, glitch, glitch_count
  );

endinterface

// File: rtl/glitch_filter_ch.sv
// One filter channel: input synchronizer, stability FSM with counter, and
// registered rise/fall/glitch pulses aligned with the dout update.
module glitch_filter_ch
  import glitch_filter_pkg::*;
#(
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_din,
  output logic o_dout,
  output logic o_rise,
  output logic o_fall,
  output logic o_glitch,
  output logic o_glitch_next
);

  localparam int            CW       = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_dout;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_glitch;

  logic w_s;
  logic w_diff;
  logic w_accept;
  logic w_glitch_next;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = w_s ^ r_dout;
  // STABLE always holds cnt=0, so with a 1-cycle filter this accepts straight from STABLE.
  assign w_accept      = i_en & w_diff & (r_cnt == CNT_LAST);
  assign w_glitch_next = i_en & (r_state == PENDING) & ~w_diff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= STABLE;
      r_cnt    <= '0;
      r_dout   <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_glitch <= w_glitch_next;
      if (!i_en) begin
        r_state <= STABLE;
        r_cnt   <= '0;
      end else if (w_accept) begin
        r_dout  <= w_s;
        r_rise  <= w_s;
        r_fall  <= ~w_s;
        r_state <= STABLE;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_state <= PENDING;
        r_cnt   <= r_cnt + CW'(1);
      end else begin
        r_state <= STABLE;
        r_cnt   <= '0;
      end
    end
  end

  assign o_dout        = r_dout;
  assign o_rise        = r_rise;
  assign o_fall        = r_fall;
  assign o_glitch      = r_glitch;
  assign o_glitch_next = w_glitch_next;

endmodule

// File: rtl/glitch_filter.sv
// WIDTH independent glitch-filter channels plus a saturating counter of
// cycles in which at least one channel rejected a pending change.
module glitch_filter
  import glitch_filter_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input logic            clk,
  input logic            reset,
  glitch_filter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] w_dout;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_glitch;
  logic [WIDTH-1:0] w_glitch_next;
  logic [CNT_W-1:0] r_glitch_count;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    glitch_filter_ch #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .i_en          (bus.en),
      .i_din         (bus.din[i]),
      .o_dout        (w_dout[i]),
      .o_rise        (w_rise[i]),
      .o_fall        (w_fall[i]),
      .o_glitch      (w_glitch[i]),
      .o_glitch_next (w_glitch_next[i])
    );
  end

  // Counts the same edge the glitch pulses are registered; clear has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_glitch_count <= '0;
    end else if (bus.clr_cnt) begin
      r_glitch_count <= '0;
    end else if ((|w_glitch_next) && (r_glitch_count != CNT_MAX)) begin
      r_glitch_count <= r_glitch_count + CNT_W'(1);
    end
  end

  assign bus.dout         = w_dout;
  assign bus.rise         = w_rise;
  assign bus.fall         = w_fall;
  assign bus.glitch       = w_glitch;
  assign bus.glitch_count = r_glitch_count;

endmodule

// File: tb/tb_glitch_filter.sv
// Directed bench for glitch_filter with WIDTH=4, FILTER_CYCLES=4, SYNC_STAGES=2, CNT_W=8.
module tb_glitch_filter;

  logic clk;
  logic reset;

  glitch_filter_if #(.WIDTH(4), .CNT_W(8)) bus ();

  glitch_filter #(
    .WIDTH         (4),
    .FILTER_CYCLES (4),
    .SYNC_STAGES   (2),
    .CNT_W         (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din;
    logic       en;
    logic       clr;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] glitch;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   bad;

  function automatic void add(input logic [3:0] din, input logic en, input logic clr,
                              input logic [3:0] dout, input logic [3:0] rise,
                              input logic [3:0] fall, input logic [3:0] glitch,
                              input logic [7:0] cnt);
    vec_t v;
    v.din = din; v.en = en; v.clr = clr;
    v.dout = dout; v.rise = rise; v.fall = fall; v.glitch = glitch; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [3:0] dout, input logic [3:0] rise,
                         input logic [3:0] fall, input logic [3:0] glitch, input logic [7:0] cnt);
    chk({nm, ".dout"},   32'(bus.dout),         32'(dout));
    chk({nm, ".rise"},   32'(bus.rise),         32'(rise));
    chk({nm, ".fall"},   32'(bus.fall),         32'(fall));
    chk({nm, ".glitch"}, 32'(bus.glitch),       32'(glitch));
    chk({nm, ".count"},  32'(bus.glitch_count), 32'(cnt));
  endtask

  initial begin
    int seen;
    total = 0;
    bad   = 0;

    // 0000 -> 0001 held: dout on the 6th edge with a single rise pulse
    for (int e = 1; e <= 5; e++) add(4'b0001, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    add(4'b0001, 1, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 8'd0);
    add(4'b0001, 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    // channel 1 high for two cycles: rejected
    add(4'b0011, 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    add(4'b0011, 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    add(4'b0001, 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    add(4'b0001, 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    add(4'b0001, 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 8'd1);
    add(4'b0001, 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'd1);
    // channel 0 falls back to 0
    for (int e = 1; e <= 5; e++) add(4'b0000, 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'd1);
    add(4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 8'd1);
    add(4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd1);
    // simultaneous glitches on channels 2 and 3 count once
    add(4'b1100, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd1);
    add(4'b1100, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd1);
    add(4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd1);
    add(4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd1);
    add(4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 8'd2);
    add(4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd2);
    // clear coincides with a glitch: clear wins
    add(4'b1100, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd2);
    add(4'b1100, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd2);
    add(4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd2);
    add(4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd2);
    add(4'b0000, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 8'd0);
    add(4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);

    reset       = 1'b1;
    bus.en      = 1'b1;
    bus.clr_cnt = 1'b0;
    bus.din     = 4'b0000;
    #2;
    chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      bus.din     = vecs[i].din;
      bus.en      = vecs[i].en;
      bus.clr_cnt = vecs[i].clr;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].rise, vecs[i].fall,
              vecs[i].glitch, vecs[i].cnt);
    end

    // 300 glitches on channel 0: counter saturates at 255
    bus.clr_cnt = 1'b0;
    seen = 0;
    for (int n = 1; n <= 300; n++) begin
      bus.din = 4'b0001; tick(); tick();
      bus.din = 4'b0000; tick(); tick(); tick();
      if (bus.glitch === 4'b0001) seen++;
      if (n == 254) chk("sat.count254", 32'(bus.glitch_count), 32'd254);
      if (n == 256) chk("sat.count256", 32'(bus.glitch_count), 32'd255);
    end
    chk("sat.pulses", 32'(seen), 32'd300);
    chk("sat.count", 32'(bus.glitch_count), 32'd255);
    chk("sat.dout", 32'(bus.dout), 32'd0);

    // establish channel 1, then reset midway through a channel 0 rise
    bus.din = 4'b0010;
    for (int e = 1; e <= 6; e++) tick();
    chk("pre_rst.dout", 32'(bus.dout), 32'b0010);
    bus.din = 4'b0011;
    for (int e = 1; e <= 4; e++) tick();
    chk("pre_rst.dout2", 32'(bus.dout), 32'b0010);
    #1 reset = 1'b1;
    #1;
    chk_all("async_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e < 6) chk($sformatf("post_rst.e%0d.dout", e), 32'(bus.dout), 32'd0);
    end
    chk_all("post_rst.e6", 4'b0011, 4'b0011, 4'b0000, 4'b0000, 8'd0);

    bus.din = 4'b0000;
    for (int e = 1; e <= 7; e++) tick();
    chk("idle.dout", 32'(bus.dout), 32'd0);

    // disabled filter: din toggles, outputs frozen
    bus.en = 1'b0;
    for (int e = 0; e < 10; e++) begin
      bus.din = e[0] ? 4'b0000 : 4'b1111;
      tick();
      chk_all($sformatf("dis.e%0d", e), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    end
    bus.din = 4'b1111;
    tick(); tick();
    chk("dis.hold.dout", 32'(bus.dout), 32'd0);
    bus.en = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("en.e%0d.dout", e), 32'(bus.dout), 32'd0);
    end
    tick();
    chk_all("en.e4", 4'b1111, 4'b1111, 4'b0000, 4'b0000, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
